// File: rtl/infoframe_packet_assembler_if.sv
// Packet request/beat-stream bundle between the packet picker and the data-island serialiser.
interface infoframe_packet_assembler_if;
    logic             packet_start;
    logic [23:0]      header;
    logic [3:0][55:0] sub;
    logic             busy;
    logic             packet_valid;
    logic             packet_last;
    logic [8:0]       packet_data;

    modport master (output packet_start, header, sub,
                    input  busy, packet_valid, packet_last, packet_data);
    modport slave  (input  packet_start, header, sub,
                    output busy, packet_valid, packet_last, packet_data);
endinterface

// File: rtl/infoframe_packet_assembler.sv
// Serialises a 28-byte data-island packet into 32 nine-bit beats with BCH parity
// generated on the fly and optional InfoFrame checksum insertion into PB0.
module infoframe_packet_assembler #(
    parameter bit INSERT_CHECKSUM = 1'b0
) (
    input logic                         clk_pixel,
    input logic                         reset,
    infoframe_packet_assembler_if.slave pkt
);
    typedef enum logic {IDLE, SEND} state_t;

    state_t           state_q, state_d;
    logic [4:0]       beat_q, beat_d;
    logic [23:0]      hdr_q, hdr_d;
    logic [3:0][55:0] sub_q, sub_d;
    logic [7:0]       ehdr_q, ehdr_d;
    logic [3:0][7:0]  esub_q, esub_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [8:0]       data_q, data_d;

    logic             accept;
    logic [7:0]       csum;
    logic [3:0][55:0] sub_in;
    logic [4:0]       b;
    logic [7:0]       eh;
    logic [3:0][7:0]  es;
    logic [5:0]       sb;
    logic [2:0]       sp;

    function automatic logic [7:0] ecc_step(input logic [7:0] e, input logic d);
        return (e >> 1) ^ (((e[0] ^ d) != 1'b0) ? 8'h83 : 8'h00);
    endfunction

    assign pkt.busy         = valid_q && !last_q;
    assign pkt.packet_valid = valid_q;
    assign pkt.packet_last  = last_q;
    assign pkt.packet_data  = data_q;

    // Checksum makes HB0..2 + PB0..27 sum to zero; the incoming PB0 is excluded.
    always_comb begin
        csum = 8'h00;
        for (int j = 0; j < 3; j++) csum = csum - pkt.header[8*j +: 8];
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 7; j++)
                if (k != 0 || j != 0) csum = csum - pkt.sub[k][8*j +: 8];
        sub_in = pkt.sub;
        if (INSERT_CHECKSUM) sub_in[0][7:0] = csum;
    end

    always_comb begin
        accept  = pkt.packet_start && !(valid_q && !last_q);
        b       = accept ? 5'd0 : beat_q + 5'd1;
        eh      = accept ? 8'h00 : ehdr_q;
        es      = accept ? '0 : esub_q;
        sb      = {b, 1'b0};
        sp      = {b[1:0], 1'b0};
        state_d = state_q;
        beat_d  = beat_q;
        hdr_d   = hdr_q;
        sub_d   = sub_q;
        ehdr_d  = ehdr_q;
        esub_d  = esub_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        data_d  = '0;
        if (accept || (state_q == SEND && beat_q != 5'd31)) begin
            state_d = SEND;
            beat_d  = b;
            valid_d = 1'b1;
            last_d  = (b == 5'd31);
            if (accept) begin
                hdr_d = pkt.header;
                sub_d = sub_in;
            end
            // Parity regs freeze once the data bits are exhausted and are then shifted out.
            if (b < 5'd24) begin
                data_d[0] = hdr_d[b];
                ehdr_d    = ecc_step(eh, hdr_d[b]);
            end else begin
                data_d[0] = eh[b[2:0]];
                ehdr_d    = eh;
            end
            for (int k = 0; k < 4; k++) begin
                if (b < 5'd28) begin
                    data_d[1+k] = sub_d[k][sb];
                    data_d[5+k] = sub_d[k][sb + 6'd1];
                    esub_d[k]   = ecc_step(ecc_step(es[k], sub_d[k][sb]), sub_d[k][sb + 6'd1]);
                end else begin
                    data_d[1+k] = es[k][sp];
                    data_d[5+k] = es[k][sp + 3'd1];
                    esub_d[k]   = es[k];
                end
            end
        end else begin
            state_d = IDLE;
            beat_d  = 5'd0;
        end
    end

    always_ff @(posedge clk_pixel or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            hdr_q   <= '0;
            sub_q   <= '0;
            ehdr_q  <= '0;
            esub_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            hdr_q   <= hdr_d;
            sub_q   <= sub_d;
            ehdr_q  <= ehdr_d;
            esub_q  <= esub_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_infoframe_packet_assembler.sv
// Bench: two assemblers (checksum off/on) driven with identical packets, checked beat by beat.
module tb_infoframe_packet_assembler;
    typedef logic [3:0][55:0] sub_t;
    typedef logic [31:0][8:0] beats_t;
    typedef logic [69:0][11:0] obs_t;

    int   tests = 0;
    int   fails = 0;
    logic clk;
    logic reset;

    infoframe_packet_assembler_if if0();
    infoframe_packet_assembler_if if1();

    infoframe_packet_assembler #(.INSERT_CHECKSUM(1'b0)) u0 (.clk_pixel(clk), .reset(reset), .pkt(if0.slave));
    infoframe_packet_assembler #(.INSERT_CHECKSUM(1'b1)) u1 (.clk_pixel(clk), .reset(reset), .pkt(if1.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] bch(input bit q[$]);
        logic [7:0] e = 8'h00;
        foreach (q[i]) e = (e >> 1) ^ ((e[0] ^ q[i]) ? 8'h83 : 8'h00);
        return e;
    endfunction

    // Reference: build each channel as a bit stream (data then parity) and deal it out.
    function automatic beats_t model(input logic [23:0] h, input sub_t s, input bit ins);
        bit hs[$];
        bit ss[$];
        beats_t r;
        logic [7:0] e;
        logic [7:0] sum;
        if (ins) begin
            sum = h[7:0] + h[15:8] + h[23:16];
            for (int p = 1; p < 28; p++) sum = sum + s[p / 7][8*(p % 7) +: 8];
            s[0][7:0] = 8'h00 - sum;
        end
        r = '0;
        for (int i = 0; i < 24; i++) hs.push_back(h[i]);
        e = bch(hs);
        for (int i = 0; i < 8; i++) hs.push_back(e[i]);
        for (int bt = 0; bt < 32; bt++) r[bt][0] = hs[bt];
        for (int k = 0; k < 4; k++) begin
            ss = {};
            for (int i = 0; i < 56; i++) ss.push_back(s[k][i]);
            e = bch(ss);
            for (int i = 0; i < 8; i++) ss.push_back(e[i]);
            for (int bt = 0; bt < 32; bt++) begin
                r[bt][1+k] = ss[2*bt];
                r[bt][5+k] = ss[2*bt+1];
            end
        end
        return r;
    endfunction

    function automatic logic [11:0] exp_word(input int i, input beats_t e);
        if (i < 0 || i > 31) return 12'h000;
        return {i != 31, 1'b1, i == 31, e[i]};
    endfunction

    function automatic sub_t rand_sub();
        sub_t s;
        for (int k = 0; k < 4; k++) s[k] = 56'({$urandom(), $urandom()});
        return s;
    endfunction

    task automatic drive(input logic st, input logic [23:0] h, input sub_t s);
        if0.packet_start = st; if0.header = h; if0.sub = s;
        if1.packet_start = st; if1.header = h; if1.sub = s;
    endtask

    // Issues one start and samples n cycles; inputs are scrambled right after the accept.
    task automatic run(input logic [23:0] h, input sub_t s, input int n, output obs_t o0, output obs_t o1);
        o0 = '0;
        o1 = '0;
        drive(1'b1, h, s);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) drive(1'b0, 24'($urandom()), rand_sub());
            o0[i] = {if0.busy, if0.packet_valid, if0.packet_last, if0.packet_data};
            o1[i] = {if1.busy, if1.packet_valid, if1.packet_last, if1.packet_data};
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b0, '0, '0);
        repeat (2) @(negedge clk);
        tests++;
        if ({if0.busy, if0.packet_valid, if0.packet_last, if0.packet_data} !== 12'h000) begin
            fails++; $display("FAIL reset_d0 got %h exp 000", {if0.busy, if0.packet_valid, if0.packet_last, if0.packet_data});
        end
        tests++;
        if ({if1.busy, if1.packet_valid, if1.packet_last, if1.packet_data} !== 12'h000) begin
            fails++; $display("FAIL reset_d1 got %h exp 000", {if1.busy, if1.packet_valid, if1.packet_last, if1.packet_data});
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_zero();
        obs_t o0, o1;
        run(24'h0, '0, 34, o0, o1);
        for (int i = 0; i < 34; i++) begin
            tests++;
            if (o0[i] !== exp_word(i, '0)) begin
                fails++; $display("FAIL zero_d0 beat %0d got %h exp %h", i, o0[i], exp_word(i, '0));
            end
            tests++;
            if (o1[i] !== exp_word(i, '0)) begin
                fails++; $display("FAIL zero_d1 beat %0d got %h exp %h", i, o1[i], exp_word(i, '0));
            end
        end
    endtask

    task automatic test_header_ecc();
        obs_t o0, o1;
        beats_t e0, e1;
        logic [7:0] eb;
        e0 = model(24'h800000, '0, 1'b0);
        e1 = model(24'h800000, '0, 1'b1);
        run(24'h800000, '0, 33, o0, o1);
        for (int i = 0; i < 8; i++) eb[i] = o0[24+i][0];
        tests++;
        if (o0[23][0] !== 1'b1) begin fails++; $display("FAIL hdr_bit23 got %b exp 1", o0[23][0]); end
        tests++;
        if (eb !== 8'h83) begin fails++; $display("FAIL hdr_ecc got %h exp 83", eb); end
        for (int i = 0; i < 33; i++) begin
            tests++;
            if (o0[i] !== exp_word(i, e0)) begin
                fails++; $display("FAIL hdr_d0 beat %0d got %h exp %h", i, o0[i], exp_word(i, e0));
            end
            tests++;
            if (o1[i] !== exp_word(i, e1)) begin
                fails++; $display("FAIL hdr_d1 beat %0d got %h exp %h", i, o1[i], exp_word(i, e1));
            end
        end
    endtask

    task automatic test_sub_ecc();
        obs_t o0, o1;
        sub_t s;
        logic [7:0] eb;
        s = '0;
        s[0] = 56'h80000000000000;
        run(24'h0, s, 33, o0, o1);
        for (int i = 0; i < 4; i++) begin
            eb[2*i]   = o0[28+i][1];
            eb[2*i+1] = o0[28+i][5];
        end
        tests++;
        if ({o0[27][5], o0[27][1]} !== 2'b10) begin
            fails++; $display("FAIL sub_bit55 got %b exp 10", {o0[27][5], o0[27][1]});
        end
        tests++;
        if (eb !== 8'h83) begin fails++; $display("FAIL sub_ecc got %h exp 83", eb); end
        for (int i = 0; i < 33; i++) begin
            tests++;
            if (o0[i] !== exp_word(i, model(24'h0, s, 1'b0))) begin
                fails++; $display("FAIL sub_d0 beat %0d got %h exp %h", i, o0[i], exp_word(i, model(24'h0, s, 1'b0)));
            end
        end
    endtask

    task automatic test_checksum();
        obs_t o0, o1;
        sub_t s;
        logic [23:0] h;
        logic [7:0] pb0, pb0_raw, sum;
        sub_t rx;
        h = 24'h050181;
        s = '0;
        s[0] = 56'h00_02_01_c4_5d_d8_7d;
        s[1] = 56'h12;
        run(h, s, 33, o0, o1);
        for (int i = 0; i < 4; i++) begin
            pb0[2*i] = o1[i][1];  pb0[2*i+1] = o1[i][5];
            pb0_raw[2*i] = o0[i][1]; pb0_raw[2*i+1] = o0[i][5];
        end
        tests++;
        if (pb0 !== 8'h6B) begin fails++; $display("FAIL csum_pb0 got %h exp 6b", pb0); end
        tests++;
        if (pb0_raw !== 8'h7D) begin fails++; $display("FAIL csum_passthru got %h exp 7d", pb0_raw); end
        rx = '0;
        sum = 8'h00;
        for (int bt = 0; bt < 28; bt++)
            for (int k = 0; k < 4; k++) begin
                rx[k][2*bt] = o1[bt][1+k];
                rx[k][2*bt+1] = o1[bt][5+k];
            end
        for (int bt = 0; bt < 24; bt++) sum = sum + (8'(o1[bt][0]) << (bt % 8));
        for (int p = 0; p < 28; p++) sum = sum + rx[p / 7][8*(p % 7) +: 8];
        tests++;
        if (sum !== 8'h00) begin fails++; $display("FAIL csum_bytesum got %h exp 00", sum); end
        for (int i = 0; i < 33; i++) begin
            tests++;
            if (o1[i] !== exp_word(i, model(h, s, 1'b1))) begin
                fails++; $display("FAIL csum_d1 beat %0d got %h exp %h", i, o1[i], exp_word(i, model(h, s, 1'b1)));
            end
        end
    endtask

    task automatic test_random();
        obs_t o0, o1;
        beats_t e0, e1;
        logic [23:0] h;
        sub_t s;
        for (int n = 0; n < 6; n++) begin
            h = 24'($urandom());
            s = rand_sub();
            e0 = model(h, s, 1'b0);
            e1 = model(h, s, 1'b1);
            run(h, s, 33, o0, o1);
            for (int i = 0; i < 33; i++) begin
                tests++;
                if (o0[i] !== exp_word(i, e0)) begin
                    fails++; $display("FAIL rand%0d_d0 beat %0d got %h exp %h", n, i, o0[i], exp_word(i, e0));
                end
                tests++;
                if (o1[i] !== exp_word(i, e1)) begin
                    fails++; $display("FAIL rand%0d_d1 beat %0d got %h exp %h", n, i, o1[i], exp_word(i, e1));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o0, o1;
        logic [23:0] ha, hb;
        sub_t sa, sb;
        logic [11:0] x0, x1;
        ha = 24'($urandom()); sa = rand_sub();
        hb = 24'($urandom()); sb = rand_sub();
        drive(1'b1, ha, sa);
        for (int i = 0; i < 66; i++) begin
            @(negedge clk);
            o0[i] = {if0.busy, if0.packet_valid, if0.packet_last, if0.packet_data};
            o1[i] = {if1.busy, if1.packet_valid, if1.packet_last, if1.packet_data};
            if (i == 31) drive(1'b1, hb, sb);
            else if (i == 37) drive(1'b1, 24'($urandom()), rand_sub());
            else drive(1'b0, 24'($urandom()), rand_sub());
        end
        for (int i = 0; i < 66; i++) begin
            x0 = (i < 32) ? exp_word(i, model(ha, sa, 1'b0)) : exp_word(i - 32, model(hb, sb, 1'b0));
            x1 = (i < 32) ? exp_word(i, model(ha, sa, 1'b1)) : exp_word(i - 32, model(hb, sb, 1'b1));
            tests++;
            if (o0[i] !== x0) begin fails++; $display("FAIL b2b_d0 cycle %0d got %h exp %h", i, o0[i], x0); end
            tests++;
            if (o1[i] !== x1) begin fails++; $display("FAIL b2b_d1 cycle %0d got %h exp %h", i, o1[i], x1); end
        end
    endtask

    task automatic test_mid_reset();
        obs_t o0, o1;
        logic [11:0] w0, w1;
        logic [23:0] h;
        sub_t s;
        h = 24'($urandom()); s = rand_sub();
        drive(1'b1, h, s);
        for (int i = 0; i <= 10; i++) begin
            @(negedge clk);
            if (i == 0) drive(1'b0, '0, '0);
            w0 = {if0.busy, if0.packet_valid, if0.packet_last, if0.packet_data};
            tests++;
            if (w0 !== exp_word(i, model(h, s, 1'b0))) begin
                fails++; $display("FAIL mid_pre beat %0d got %h exp %h", i, w0, exp_word(i, model(h, s, 1'b0)));
            end
        end
        reset = 1'b1;
        #1;
        w0 = {if0.busy, if0.packet_valid, if0.packet_last, if0.packet_data};
        w1 = {if1.busy, if1.packet_valid, if1.packet_last, if1.packet_data};
        tests++;
        if (w0 !== 12'h000) begin fails++; $display("FAIL mid_async_d0 got %h exp 000", w0); end
        tests++;
        if (w1 !== 12'h000) begin fails++; $display("FAIL mid_async_d1 got %h exp 000", w1); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        h = 24'($urandom()); s = rand_sub();
        run(h, s, 33, o0, o1);
        for (int i = 0; i < 33; i++) begin
            tests++;
            if (o0[i] !== exp_word(i, model(h, s, 1'b0))) begin
                fails++; $display("FAIL mid_post_d0 beat %0d got %h exp %h", i, o0[i], exp_word(i, model(h, s, 1'b0)));
            end
            tests++;
            if (o1[i] !== exp_word(i, model(h, s, 1'b1))) begin
                fails++; $display("FAIL mid_post_d1 beat %0d got %h exp %h", i, o1[i], exp_word(i, model(h, s, 1'b1)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_header_ecc();
        test_sub_ecc();
        test_checksum();
        test_random();
        test_back_to_back();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
